// File: rtl/loader_pkg.sv
// Shared types and constants for the program loader.
// The state encoding is fixed here so the top, the checksum unit and any
// external checker agree on it.
package loader_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RECV  = 3'd1,
        S_WRITE = 3'd2,
        S_CHECK = 3'd3,
        S_DONE  = 3'd4,
        S_ERR   = 3'd5
    } state_t;

    // A new session may only be opened from a resting state.
    function automatic logic can_start(input state_t s);
        return (s == S_IDLE) || (s == S_DONE) || (s == S_ERR);
    endfunction

endpackage

// File: rtl/loader_csum.sv
// Running 8-bit checksum for a load session.
// Accumulates every data byte modulo 256 and compares the total against the
// trailing checksum byte supplied by the host. The module only exists when
// LOADER_CHECKSUM_EN is defined; without it the loader has no checksum path.
`ifdef LOADER_CHECKSUM_EN
module loader_csum
    import loader_pkg::*;
(
    input  logic              clk,
    input  logic              clr,
    input  logic              clear_i,
    input  logic              add_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [DATA_W-1:0] cmp_i,
    output logic              match_o
);

    logic [DATA_W-1:0] sum_q;
    logic [DATA_W-1:0] sum_d;

    // Modulo-256 wrap is intended: the host computes the same truncated sum.
    assign sum_d = sum_q + data_i;

    // Accumulator: cleared by reset or at session start, otherwise adds accepted bytes.
    always_ff @(posedge clk) begin
        if (clr || clear_i) begin
            sum_q <= '0;
        end else if (add_i) begin
            sum_q <= sum_d;
        end
    end

    assign match_o = (cmp_i == sum_q);

endmodule
`endif

// File: rtl/program_loader.sv
// Program loader: receives WORDS bytes from a host over a valid/ready byte
// stream, writes them to program RAM at consecutive addresses starting at 0,
// and holds the processor in clear while loading.
// Optional feature macro: LOADER_CHECKSUM_EN adds a trailing checksum byte,
// a CHECK state and an ERR outcome; without it every session ends in DONE.
// dbg_state exposes the FSM state for external checkers.
module program_loader
    import loader_pkg::*;
#(
    parameter int WORDS  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              start,
    input  logic              host_valid,
    input  logic [7:0]        host_data,
    output logic              host_ready,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [2:0]        dbg_state
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(WORDS - 1);

    state_t            state_q;
    logic [ADDR_W-1:0] cnt_q;
    logic [ADDR_W-1:0] cnt_d;
    logic              host_ready_q;
    logic              ram_we_q;
    logic [ADDR_W-1:0] ram_addr_q;
    logic [DATA_W-1:0] ram_wdata_q;
    logic              cpu_hold_q;
    logic              busy_q;
    logic              done_q;

    logic              xfer;
    logic              last_word;
    logic              start_ok;

    // Handshake: a byte moves exactly when host_valid && host_ready are both
    // high at a rising edge. host_ready is registered and only high in RECV and
    // CHECK; the host must keep host_data stable until that edge, and
    // host_valid while host_ready is low has no effect.
    assign xfer      = host_valid && host_ready_q;
    assign last_word = (cnt_q == LAST);
    assign start_ok  = start && can_start(state_q);

    // Saturating next address so the counter can never run past WORDS-1.
    assign cnt_d = last_word ? cnt_q : cnt_q + ADDR_W'(1);

`ifdef LOADER_CHECKSUM_EN
    logic err_q;
    logic csum_clear;
    logic csum_add;
    logic csum_match;

    assign csum_clear = start_ok;
    assign csum_add   = (state_q == S_RECV) && xfer;

    loader_csum u_csum (
        .clk     (clk),
        .clr     (clr),
        .clear_i (csum_clear),
        .add_i   (csum_add),
        .data_i  (host_data),
        .cmp_i   (host_data),
        .match_o (csum_match)
    );
`endif

    // Session FSM with all outputs registered alongside the state transition.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            host_ready_q <= 1'b0;
            ram_we_q     <= 1'b0;
            ram_addr_q   <= '0;
            ram_wdata_q  <= '0;
            cpu_hold_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            err_q        <= 1'b0;
`endif
        end else begin
            // Write strobe is a single-cycle pulse; only the RECV accept sets it.
            ram_we_q <= 1'b0;
            if (start_ok) begin
                state_q      <= S_RECV;
                cnt_q        <= '0;
                host_ready_q <= 1'b1;
                cpu_hold_q   <= 1'b1;
                busy_q       <= 1'b1;
                done_q       <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
                err_q        <= 1'b0;
`endif
            end else begin
                case (state_q)
                    S_RECV: begin
                        if (xfer) begin
                            state_q      <= S_WRITE;
                            host_ready_q <= 1'b0;
                            ram_we_q     <= 1'b1;
                            ram_addr_q   <= cnt_q;
                            ram_wdata_q  <= host_data;
                        end
                    end
                    S_WRITE: begin
                        cnt_q <= cnt_d;
                        if (last_word) begin
`ifdef LOADER_CHECKSUM_EN
                            state_q      <= S_CHECK;
                            host_ready_q <= 1'b1;
`else
                            state_q      <= S_DONE;
                            busy_q       <= 1'b0;
                            cpu_hold_q   <= 1'b0;
                            done_q       <= 1'b1;
`endif
                        end else begin
                            state_q      <= S_RECV;
                            host_ready_q <= 1'b1;
                        end
                    end
`ifdef LOADER_CHECKSUM_EN
                    S_CHECK: begin
                        if (xfer) begin
                            host_ready_q <= 1'b0;
                            busy_q       <= 1'b0;
                            if (csum_match) begin
                                state_q    <= S_DONE;
                                cpu_hold_q <= 1'b0;
                                done_q     <= 1'b1;
                            end else begin
                                // Processor stays held: it must never run a corrupt image.
                                state_q    <= S_ERR;
                                err_q      <= 1'b1;
                            end
                        end
                    end
`endif
                    default: begin
                        // IDLE, DONE and ERR rest until start or clr.
                    end
                endcase
            end
        end
    end

    assign host_ready = host_ready_q;
    assign ram_we     = ram_we_q;
    assign ram_addr   = ram_addr_q;
    assign ram_wdata  = ram_wdata_q;
    assign cpu_hold   = cpu_hold_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign dbg_state  = state_q;
`ifdef LOADER_CHECKSUM_EN
    assign err        = err_q;
`else
    assign err        = 1'b0;
`endif

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader (default WORDS=16, ADDR_W=4).
// Checksum sessions are exercised when LOADER_CHECKSUM_EN is defined.
module tb_program_loader;
    import loader_pkg::*;

    localparam int WORDS  = 16;
    localparam int ADDR_W = 4;

    logic              clk = 1'b0;
    logic              clr;
    logic              start;
    logic              host_valid;
    logic [7:0]        host_data;
    logic              host_ready;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [7:0]        ram_wdata;
    logic              cpu_hold;
    logic              busy;
    logic              done;
    logic              err;
    logic [2:0]        dbg_state;

    int total = 0;
    int bad   = 0;

    logic [ADDR_W+7:0] exp_q[$];
    logic [ADDR_W+7:0] mon_e;
    logic [7:0]        ram_img[WORDS];
    int                wr_count = 0;
    logic [7:0]        tb_sum;

    program_loader #(.WORDS(WORDS), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .clr        (clr),
        .start      (start),
        .host_valid (host_valid),
        .host_data  (host_data),
        .host_ready (host_ready),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .cpu_hold   (cpu_hold),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .dbg_state  (dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every RAM write must match the next expected {addr,data}.
    always @(negedge clk) begin
        if (ram_we === 1'b1) begin
            check("write_expected", (exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                check("write_addr_data", {ram_addr, ram_wdata}, mon_e);
                ram_img[ram_addr] = ram_wdata;
                wr_count++;
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic logic [7:0] data_for(input int mode, input int i);
        case (mode)
            0:       return 8'(i);
            1:       return 8'h01;
            default: return 8'hF0 ^ 8'(i);
        endcase
    endfunction

    // Presents one byte after 'gap' idle cycles and waits for it to be taken.
    task automatic send_byte(input logic [7:0] b, input int gap, input bit is_data);
        int waited;
        waited = 0;
        if (gap > 0) begin
            host_valid = 1'b0;
            repeat (gap) tick();
        end
        host_data  = b;
        host_valid = 1'b1;
        while (host_ready !== 1'b1 && waited < 20) begin
            tick();
            waited++;
        end
        check("accept_timeout", (waited < 20), 1);
        tick();
        if (is_data) begin
            check("we_latency", ram_we, 1);
            check("ready_in_write", host_ready, 0);
        end
    endtask

    task automatic begin_session();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_state", dbg_state, S_RECV);
        check("start_busy", busy, 1);
        check("start_hold", cpu_hold, 1);
        check("start_ready", host_ready, 1);
        check("start_done", done, 0);
        check("start_err", err, 0);
    endtask

    task automatic load_words(input int mode, input int gap);
        tb_sum = 8'h00;
        for (int i = 0; i < WORDS; i++) begin
            logic [7:0] d;
            d = data_for(mode, i);
            exp_q.push_back({ADDR_W'(i), d});
            tb_sum = tb_sum + d;
            send_byte(d, gap, 1'b1);
        end
    endtask

    // Called on the negedge of the last WRITE cycle.
    task automatic end_session(input logic [7:0] csum_byte, input bit expect_ok);
        tick();
`ifdef LOADER_CHECKSUM_EN
        check("check_state", dbg_state, S_CHECK);
        check("check_ready", host_ready, 1);
        check("check_busy", busy, 1);
        send_byte(csum_byte, 0, 1'b0);
        host_valid = 1'b0;
        check("end_we", ram_we, 0);
        check("end_busy", busy, 0);
        check("end_ready", host_ready, 0);
        if (expect_ok) begin
            check("end_state", dbg_state, S_DONE);
            check("end_done", done, 1);
            check("end_err", err, 0);
            check("end_hold", cpu_hold, 0);
        end else begin
            check("end_state", dbg_state, S_ERR);
            check("end_done", done, 0);
            check("end_err", err, 1);
            check("end_hold", cpu_hold, 1);
        end
`else
        host_valid = 1'b0;
        check("end_state", dbg_state, S_DONE);
        check("end_we", ram_we, 0);
        check("end_busy", busy, 0);
        check("end_ready", host_ready, 0);
        check("end_done", done, 1);
        check("end_err", err, 0);
        check("end_hold", cpu_hold, 0);
`endif
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_state"}, dbg_state, S_IDLE);
        check({tag, "_ready"}, host_ready, 0);
        check({tag, "_we"}, ram_we, 0);
        check({tag, "_addr"}, ram_addr, 0);
        check({tag, "_wdata"}, ram_wdata, 0);
        check({tag, "_hold"}, cpu_hold, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_err"}, err, 0);
    endtask

    task automatic clear_image();
        for (int i = 0; i < WORDS; i++) ram_img[i] = 8'hEE;
        wr_count = 0;
    endtask

    // Watchdog: guarantees the run ends even if the DUT stalls.
    initial begin
        #100000;
        bad++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        clr        = 1'b1;
        start      = 1'b0;
        host_valid = 1'b0;
        host_data  = 8'h00;
        clear_image();
        repeat (2) tick();
        check_reset_outputs("reset");
        clr = 1'b0;
        tick();
        check("idle_state", dbg_state, S_IDLE);

        // host_valid in IDLE is ignored
        host_valid = 1'b1;
        host_data  = 8'h55;
        repeat (3) tick();
        check("idle_valid_ready", host_ready, 0);
        check("idle_valid_state", dbg_state, S_IDLE);
        check("idle_valid_writes", wr_count, 0);
        host_valid = 1'b0;

        // Nominal load 0x00..0x0F with a stray start during RECV
        begin_session();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_in_recv_state", dbg_state, S_RECV);
        check("start_in_recv_writes", wr_count, 0);
        load_words(0, 0);
        end_session(8'h78, 1'b1);
        check("nominal_writes", wr_count, WORDS);
        for (int i = 0; i < WORDS; i++) check("nominal_image", ram_img[i], 8'(i));
        host_valid = 1'b1;
        repeat (3) tick();
        host_valid = 1'b0;
        check("done_sticky", done, 1);
        check("done_sticky_state", dbg_state, S_DONE);

        // Backpressure: host_valid alternates low/high
        clear_image();
        begin_session();
        load_words(0, 1);
        end_session(8'h78, 1'b1);
        check("bp_writes", wr_count, WORDS);
        for (int i = 0; i < WORDS; i++) check("bp_image", ram_img[i], 8'(i));

        // Reset mid-load after the 5th byte, with competing start and host byte
        clear_image();
        begin_session();
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back({ADDR_W'(i), 8'h30 + 8'(i)});
            send_byte(8'h30 + 8'(i), 0, 1'b1);
        end
        clr        = 1'b1;
        start      = 1'b1;
        host_valid = 1'b1;
        host_data  = 8'hAA;
        tick();
        check_reset_outputs("midclr");
        clr        = 1'b0;
        start      = 1'b0;
        host_valid = 1'b0;
        repeat (2) tick();
        check("post_clr_state", dbg_state, S_IDLE);
        check("post_clr_writes", wr_count, 5);
        begin_session();
        load_words(2, 0);
        end_session(tb_sum, 1'b1);
        check("reload_writes", wr_count, 5 + WORDS);
        check("reload_first", ram_img[0], 8'hF0);
        check("reload_last", ram_img[WORDS-1], 8'hFF);

`ifdef LOADER_CHECKSUM_EN
        // Good checksum then bad checksum
        begin_session();
        load_words(1, 0);
        end_session(8'h10, 1'b1);
        begin_session();
        load_words(1, 0);
        end_session(8'h11, 1'b0);
        tick();
        check("err_sticky", err, 1);
        begin_session();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check_reset_outputs("err_clr");
`endif

        check("exp_queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
